fb_scanout: RTL



---
 rtl/fb_scanout.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: read side of the 1-bit framebuffer.
//
// Generates VGA timing (640x480@60 by default) from the pixel clock, issues one
// sequential, row-major read per active pixel, and re-aligns the returned
// pixel bit with delayed blank/sync so that all vga_* outputs change together.
// Pixel (x,y) reaches vga_* exactly RD_LAT+2 clocks after the counters hold
// (x,y).
//
// Ports:
//   clk        pixel clock
//   rst        asynchronous, active-low reset
//   rd_en      read strobe to the pixel memory (one per active pixel)
//   rd_addr    linear row-major pixel address, valid with rd_en
//   rd_data    pixel bit, valid RD_LAT clocks after rd_en
//   in_display active-video flag, aligned with vga_*
//   frame      one-clock strobe at the start of vertical blanking
//   line       one-clock strobe at the start of each horizontal blanking
//   vga_r/g/b  monochrome colour, forced to 0 outside active video
//   vga_hs     horizontal sync, active-low
//   vga_vs     vertical sync, active-low
module fb_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              in_display,
  output logic              frame,
  output logic              line,
  output logic              vga_r,
  output logic              vga_g,
  output logic              vga_b,
  output logic              vga_hs,
  output logic              vga_vs
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW      = $clog2(H_TOTAL);
  localparam int unsigned VCW      = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HCW-1:0]    hcnt_q, hcnt_d;
  logic [VCW-1:0]    vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              h_last, v_last;
  logic              act0, hs0, vs0;
  logic              frame_d, line_d;

  // Bit 0 is the rd_en stage; bit RD_LAT lines up with rd_data.
  logic [RD_LAT:0]   act_q, hs_q, vs_q;

  logic              disp_q, rgb_q, hs_out_q, vs_out_q;
  logic              frame_q, line_q;

  always_comb begin
    h_last = (hcnt_q == HCW'(H_TOTAL - 1));
    v_last = (vcnt_q == VCW'(V_TOTAL - 1));

    hcnt_d = h_last ? '0 : hcnt_q + HCW'(1);
    vcnt_d = vcnt_q;
    if (h_last) begin
      vcnt_d = v_last ? '0 : vcnt_q + VCW'(1);
    end

    act0 = (hcnt_q < HCW'(H_ACTIVE)) && (vcnt_q < VCW'(V_ACTIVE));
    hs0  = !((hcnt_q >= HCW'(HS_START)) && (hcnt_q < HCW'(HS_END)));
    vs0  = !((vcnt_q >= VCW'(VS_START)) && (vcnt_q < VCW'(VS_END)));

    frame_d = (hcnt_q == '0) && (vcnt_q == VCW'(V_ACTIVE));
    line_d  = (hcnt_q == HCW'(H_ACTIVE));

    // Address restarts on the frame wrap; otherwise it steps once per issued read.
    addr_d = addr_q;
    if (h_last && v_last) begin
      addr_d = '0;
    end else if (act_q[0]) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      addr_q   <= '0;
      act_q    <= '0;
      hs_q     <= '1;
      vs_q     <= '1;
      disp_q   <= 1'b0;
      rgb_q    <= 1'b0;
      hs_out_q <= 1'b1;
      vs_out_q <= 1'b1;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      addr_q   <= addr_d;
      act_q    <= {act_q[RD_LAT-1:0], act0};
      hs_q     <= {hs_q[RD_LAT-1:0], hs0};
      vs_q     <= {vs_q[RD_LAT-1:0], vs0};
      disp_q   <= act_q[RD_LAT];
      // Blanking masks whatever the memory returns outside active video.
      rgb_q    <= rd_data & act_q[RD_LAT];
      hs_out_q <= hs_q[RD_LAT];
      vs_out_q <= vs_q[RD_LAT];
      frame_q  <= frame_d;
      line_q   <= line_d;
    end
  end

  assign rd_en      = act_q[0];
  assign rd_addr    = addr_q;
  assign in_display = disp_q;
  assign frame      = frame_q;
  assign line       = line_q;
  assign vga_r      = rgb_q;
  assign vga_g      = rgb_q;
  assign vga_b      = rgb_q;
  assign vga_hs     = hs_out_q;
  assign vga_vs     = vs_out_q;

endmodule
